// File: rtl/inst_trace_ring_if.sv
// Commit-trace ring bus: commit-side inputs, host drain handshake, status and debug state.
// Drain handshake: a record moves on a rising edge where out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0 all out_* hold.
interface inst_trace_ring_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   in_inst;
  logic [63:0]   in_dnpc;
  logic          in_kill;
  logic          in_invalid;
  logic          in_en;
  logic          dump_req;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [63:0]   out_dnpc;
  logic          out_invalid;
  logic          out_last;
  logic          frozen;
  logic [CW-1:0] count;
  logic [1:0]    dbg_state;

  modport master (
    output in_inst, in_dnpc, in_kill, in_invalid, in_en, dump_req, out_ready,
    input  out_valid, out_inst, out_dnpc, out_invalid, out_last, frozen, count, dbg_state
  );

  modport slave (
    input  in_inst, in_dnpc, in_kill, in_invalid, in_en, dump_req, out_ready,
    output out_valid, out_inst, out_dnpc, out_invalid, out_last, frozen, count, dbg_state
  );
endinterface

// File: rtl/inst_trace_ring.sv
// Ring buffer of the last DEPTH committed instructions; freezes on dump or illegal
// instruction and drains oldest-first over a valid/ready handshake.
module inst_trace_ring #(
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  inst_trace_ring_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    RECORD = 2'd0,
    DRAIN  = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]      mem_inst [DEPTH];
  logic [63:0]      mem_dnpc [DEPTH];
  logic [DEPTH-1:0] mem_inv;

  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_wr;
  logic [CW-1:0] count, count_wr;
  logic          wr_en, trigger, xfer;

  // wr_ptr_wr/count_wr are the post-write values, so a triggering commit is part of the drain.
  always_comb begin
    wr_en     = (state == RECORD) && bus.in_en && !bus.in_kill;
    trigger   = (state == RECORD) && (bus.dump_req || (wr_en && bus.in_invalid));
    xfer      = (state == DRAIN) && bus.out_ready;
    wr_ptr_wr = wr_en ? wr_ptr + AW'(1) : wr_ptr;
    count_wr  = (wr_en && (count != FULL)) ? count + CW'(1) : count;
  end

  always_comb begin
    state_next = state;
    case (state)
      RECORD: if (trigger) state_next = (count_wr != '0) ? DRAIN : DONE;
      DRAIN:  if (xfer && (count == CW'(1))) state_next = DONE;
      DONE:   state_next = DONE;
      default: state_next = RECORD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RECORD;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        RECORD: begin
          wr_ptr <= wr_ptr_wr;
          count  <= count_wr;
          // When full, the low bits of count are zero and the oldest entry sits at wr_ptr_wr.
          if (trigger) rd_ptr <= wr_ptr_wr - count_wr[AW-1:0];
        end
        DRAIN: begin
          if (xfer) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately unreset; count=0 keeps stale entries from ever being shown.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_inst[wr_ptr] <= bus.in_inst;
      mem_dnpc[wr_ptr] <= bus.in_dnpc;
      mem_inv[wr_ptr]  <= bus.in_invalid;
    end
  end

  always_comb begin
    bus.out_valid   = (state == DRAIN);
    bus.out_last    = (state == DRAIN) && (count == CW'(1));
    bus.frozen      = (state != RECORD);
    bus.count       = count;
    bus.dbg_state   = state;
    bus.out_inst    = bus.out_valid ? mem_inst[rd_ptr] : '0;
    bus.out_dnpc    = bus.out_valid ? mem_dnpc[rd_ptr] : '0;
    bus.out_invalid = bus.out_valid ? mem_inv[rd_ptr]  : 1'b0;
  end
endmodule

// File: tb/tb_inst_trace_ring.sv
// Directed bench for inst_trace_ring: commits feed a depth-limited expected queue
// that is popped and compared as the ring drains.
module tb_inst_trace_ring;
  localparam int DEPTH = 16;
  localparam int W     = 97;  // {invalid, dnpc, inst}
  localparam logic [1:0] S_RECORD = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  inst_trace_ring_if #(.DEPTH(DEPTH)) bus ();

  inst_trace_ring #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  bit           rec_on = 1'b1;
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_inst    = '0;
    bus.in_dnpc    = '0;
    bus.in_kill    = 1'b0;
    bus.in_invalid = 1'b0;
    bus.in_en      = 1'b0;
    bus.dump_req   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    rec_on = 1'b1;
  endtask

  task automatic commit(input logic [31:0] inst, input logic [63:0] dnpc,
                        input bit en, input bit kill, input bit inv);
    @(negedge clock);
    bus.in_inst    = inst;
    bus.in_dnpc    = dnpc;
    bus.in_en      = en;
    bus.in_kill    = kill;
    bus.in_invalid = inv;
    if (rec_on && en && !kill) begin
      exp_q.push_back({inv, dnpc, inst});
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      if (inv) rec_on = 1'b0;
    end
    @(posedge clock);
    #1 idle_inputs();
  endtask

  task automatic dump();
    @(negedge clock);
    bus.dump_req = 1'b1;
    if (rec_on) rec_on = 1'b0;
    @(posedge clock);
    #1 bus.dump_req = 1'b0;
  endtask

  // Drains up to max_n records with a repeating 4-cycle ready pattern (bit k = cycle k).
  task automatic drain(input logic [3:0] pat, input int max_n, input int budget);
    int k = 0;
    int cyc = 0;
    int got = 0;
    bit held_v = 1'b0;
    logic [W-1:0] held = '0;
    logic [W-1:0] obs;
    while (exp_q.size() > 0 && got < max_n && cyc < budget) begin
      @(negedge clock);
      bus.out_ready = pat[k];
      if (bus.out_valid) begin
        obs = {bus.out_invalid, bus.out_dnpc, bus.out_inst};
        check("drain_record", obs, exp_q[0]);
        check("drain_last", W'(bus.out_last), W'(exp_q.size() == 1));
        if (held_v) check("stall_stable", obs, held);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          got++;
          held_v = 1'b0;
        end else begin
          held   = obs;
          held_v = 1'b1;
        end
      end
      k = (k + 1) % 4;
      cyc++;
    end
    if (got < max_n && exp_q.size() > 0) check("drain_timeout", W'(got), W'(max_n));
  endtask

  task automatic check_done(input string tag);
    @(negedge clock);
    bus.out_ready = 1'b0;
    check({tag, "_state"}, W'(bus.dbg_state), W'(S_DONE));
    check({tag, "_valid"}, W'(bus.out_valid), W'(0));
    check({tag, "_last"}, W'(bus.out_last), W'(0));
    check({tag, "_count"}, W'(bus.count), W'(0));
    check({tag, "_frozen"}, W'(bus.frozen), W'(1));
  endtask

  initial begin
    bus.out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clock);
    check("rst_state", W'(bus.dbg_state), W'(S_RECORD));
    check("rst_valid", W'(bus.out_valid), W'(0));
    check("rst_frozen", W'(bus.frozen), W'(0));
    check("rst_count", W'(bus.count), W'(0));
    check("rst_data", {bus.out_invalid, bus.out_dnpc, bus.out_inst}, W'(0));
    reset = 1'b0;

    // Five commits, dump, drain in order with ready held high.
    for (int i = 1; i <= 5; i++) commit(32'(i), 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0, 1'b0);
    check("basic_count", W'(bus.count), W'(5));
    dump();
    check("basic_frozen", W'(bus.frozen), W'(1));
    check("basic_valid1", W'(bus.out_valid), W'(1));
    drain(4'b1111, 100, 50);
    check_done("basic_done");

    // Wrap-around: 20 commits then an illegal one; keeps the newest 16.
    do_reset();
    for (int i = 1; i <= 20; i++) commit(32'(i), 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0, 1'b0);
    check("wrap_count_pre", W'(bus.count), W'(DEPTH));
    commit(32'd21, 64'h8000_0000 + 64'd84, 1'b1, 1'b0, 1'b1);
    check("wrap_count", W'(bus.count), W'(DEPTH));
    check("wrap_valid1", W'(bus.out_valid), W'(1));
    check("wrap_q_size", W'(exp_q.size()), W'(DEPTH));
    drain(4'b1111, 100, 60);
    check_done("wrap_done");

    // Killed and disabled slots interleaved with three good commits.
    do_reset();
    commit(32'hA1, 64'h100, 1'b1, 1'b0, 1'b0);
    commit(32'hDEAD, 64'h104, 1'b1, 1'b1, 1'b0);
    commit(32'hA2, 64'h108, 1'b1, 1'b0, 1'b0);
    commit(32'hBEEF, 64'h10C, 1'b0, 1'b0, 1'b0);
    commit(32'hBAD, 64'h110, 1'b1, 1'b1, 1'b1);
    commit(32'hA3, 64'h114, 1'b1, 1'b0, 1'b0);
    check("kill_count", W'(bus.count), W'(3));
    dump();
    drain(4'b1111, 100, 30);
    check_done("kill_done");

    // Dump with nothing recorded goes straight to DONE; later commits are ignored.
    do_reset();
    dump();
    check("empty_state", W'(bus.dbg_state), W'(S_DONE));
    check("empty_frozen", W'(bus.frozen), W'(1));
    commit(32'h55, 64'h200, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("empty_novalid", W'(bus.out_valid), W'(0));
    end
    check("empty_count", W'(bus.count), W'(0));

    // Stalled drain with ready pattern 1,0,0,1.
    do_reset();
    for (int i = 0; i < 4; i++)
      commit($urandom, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
    dump();
    drain(4'b1001, 100, 40);
    check_done("stall_done");

    // Asynchronous reset after two of four records have drained.
    do_reset();
    for (int i = 0; i < 4; i++)
      commit(32'h300 + 32'(i), 64'h4000 + 64'(8 * i), 1'b1, 1'b0, 1'b0);
    dump();
    drain(4'b1111, 2, 20);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", W'(bus.out_valid), W'(0));
    check("arst_count", W'(bus.count), W'(0));
    check("arst_frozen", W'(bus.frozen), W'(0));
    check("arst_state", W'(bus.dbg_state), W'(S_RECORD));
    check("arst_wr_ptr", W'(dut.wr_ptr), W'(0));
    check("arst_data", {bus.out_invalid, bus.out_dnpc, bus.out_inst}, W'(0));
    bus.out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    rec_on = 1'b1;
    commit(32'h777, 64'h5000, 1'b1, 1'b0, 1'b0);
    commit(32'h778, 64'h5004, 1'b1, 1'b0, 1'b0);
    check("arst_wr_ptr2", W'(dut.wr_ptr), W'(2));
    dump();
    drain(4'b1111, 100, 20);
    check_done("arst_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_trace_ring.md
INST_TRACE_RING -- requirements
Module: inst_trace_ring

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the number of commit records retained; power of two, 2..256.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_inst  input  32  committed instruction word.
REQ-005 SHALL have port in_dnpc  input  64  dynamic next PC of the committed instruction.
REQ-006 SHALL have port in_kill  input  1  commit slot was flushed.
REQ-007 SHALL have port in_invalid  input  1  committed instruction was illegal.
REQ-008 SHALL have port in_en  input  1  commit slot valid this cycle.
REQ-009 SHALL have port dump_req  input  1  host request to freeze and drain.
REQ-010 SHALL have port out_valid  output  1  drain record available.
REQ-011 SHALL have port out_ready  input  1  host accepts drain record.
REQ-012 SHALL have port out_inst  output  32  drained instruction word.
REQ-013 SHALL have port out_dnpc  output  64  drained dnpc.
REQ-014 SHALL have port out_invalid  output  1  drained record's invalid flag.
REQ-015 SHALL have port out_last  output  1  current drain record is the final one.
REQ-016 SHALL have port frozen  output  1  buffer no longer recording (DRAIN or DONE).
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  number of records held.

Function
REQ-018 SHALL implement states RECORD, DRAIN, DONE; reset state RECORD.
REQ-019 In RECORD, a cycle with in_en=1 and in_kill=0 SHALL write {in_inst, in_dnpc, in_invalid} at wr_ptr, advance wr_ptr by 1 modulo DEPTH, and increment count, saturating at DEPTH.
REQ-020 Cycles with in_en=0 or in_kill=1 SHALL NOT write and SHALL NOT change count.
REQ-021 Once count=DEPTH, each new write SHALL overwrite the oldest record, so the buffer always holds the most recent DEPTH commits.
REQ-022 A freeze trigger SHALL be dump_req=1, or in_en=1 with in_kill=0 and in_invalid=1, sampled in RECORD.
REQ-023 When a record write and a freeze trigger occur in the same cycle, the record SHALL be written first and included in the drain.
REQ-024 On a trigger edge, the next state SHALL be DRAIN if the post-write count>0, otherwise DONE.
REQ-025 On entering DRAIN, rd_ptr SHALL load (wr_ptr_after_write - count) mod DEPTH so that the oldest record drains first.
REQ-026 In DRAIN:
- out_valid=1, with out_inst/out_dnpc/out_invalid read from entry rd_ptr.
- out_last=1 when count=1.
REQ-027 The drain handshake SHALL be defined as follows:
- Transfer occurs on an edge with out_valid=1 and out_ready=1; rd_ptr then advances modulo DEPTH and count decrements.
- Transfer with out_last=1 moves the state to DONE.
REQ-028 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-029 In DRAIN and DONE, in_* and dump_req SHALL be ignored; no writes occur.
REQ-030 DONE SHALL persist until reset, with out_valid=0, out_last=0, count=0, frozen=1.
REQ-031 frozen SHALL be 1 exactly when state is DRAIN or DONE.
REQ-032 First out_valid SHALL occur one cycle after the trigger edge; latency per record is one cycle when out_ready is held at 1.
REQ-033 out_* data SHALL be don't-care when out_valid=0 but SHALL NOT be X after reset; drive 0.

Reset
REQ-034 Asserting reset at any time, including mid-DRAIN, SHALL immediately force:
- state=RECORD, wr_ptr=rd_ptr=0, count=0;
- out_valid=0, out_last=0, frozen=0, out_inst=0, out_dnpc=0, out_invalid=0.
REQ-035 Record storage contents SHALL NOT require reset; stale entries SHALL never be presented because count=0.

Verification
REQ-036 DEPTH=16, 5 commits (inst 0x1..0x5, dnpc 0x80000004..0x80000014), then dump_req with out_ready=1 -> 5 records drained in order 0x1..0x5; out_last only on 0x5; then DONE.
REQ-037 20 commits (inst 1..20), then an invalid commit of inst 21 -> count=16; drain yields 6..21, and inst 21 carries out_invalid=1.
REQ-038 Commits with in_kill=1 or in_en=0 interleaved among 3 good commits, then dump -> exactly 3 records; killed instructions are absent.
REQ-039 dump_req with an empty buffer -> DONE on the next cycle; out_valid never asserts; frozen=1.
REQ-040 Drain with out_ready toggling 1,0,0,1 -> out_* stable during the stall; no record skipped or duplicated.
REQ-041 reset pulsed after 2 of 4 records drained -> out_valid=0 and count=0 asynchronously; new commits are recorded from wr_ptr=0.
